// File: rtl/noc_port_arbiter_if.sv
// Handshake bundle between the requesting input ports, the output-port arbiter and the downstream link.
// The slave modport is the arbiter's view; master is the requesters plus the downstream consumer.
interface noc_port_arbiter_if #(
  parameter int FLIT_WIDTH = 32,
  parameter int INPUTS     = 5
);
  logic [INPUTS-1:0][FLIT_WIDTH-1:0] in_flit;
  logic [INPUTS-1:0]                 in_last;
  logic [INPUTS-1:0]                 in_valid;
  logic [INPUTS-1:0]                 in_ready;
  logic [FLIT_WIDTH-1:0]             out_flit;
  logic                              out_last;
  logic                              out_valid;
  logic                              out_ready;

  modport slave (
    input  in_flit, in_last, in_valid, out_ready,
    output in_ready, out_flit, out_last, out_valid
  );

  modport master (
    output in_flit, in_last, in_valid, out_ready,
    input  in_ready, out_flit, out_last, out_valid
  );
endinterface

// File: rtl/noc_port_arbiter.sv
// Wormhole round-robin output-port arbiter with a one-entry registered output slice.
// Optional stall watchdog and sticky stall_err port are enabled by defining NOC_ARB_WATCHDOG_EN.
module noc_port_arbiter #(
  parameter int FLIT_WIDTH  = 32,
  parameter int INPUTS      = 5,
  parameter int STALL_LIMIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  noc_port_arbiter_if.slave ar,
  output logic [INPUTS-1:0] grant,
  output logic              busy
`ifdef NOC_ARB_WATCHDOG_EN
  ,
  output logic              stall_err
`endif
);

  localparam int PTR_W = (INPUTS > 1) ? $clog2(INPUTS) : 1;

  typedef logic [PTR_W-1:0] idx_t;
  typedef enum logic {IDLE, LOCKED} state_t;

  if (INPUTS < 2 || STALL_LIMIT < 1) begin : g_bad_params
    $error("noc_port_arbiter: INPUTS must be >= 2 and STALL_LIMIT >= 1");
  end

  function automatic idx_t wrap_idx(input int value);
    return idx_t'(value % INPUTS);
  endfunction

  state_t                state_q, state_d;
  idx_t                  last_q, last_d;
  idx_t                  owner_q, owner_d;
  logic [INPUTS-1:0]     grant_q, grant_d;
  logic [FLIT_WIDTH-1:0] out_flit_q;
  logic                  out_last_q;
  logic                  out_valid_q;

  logic                  slot_free;
  logic                  cand_found;
  idx_t                  cand;
  logic                  xfer;
  idx_t                  sel;
  logic [INPUTS-1:0]     ready;

  // The slot can take a flit when empty or when it drains this same cycle.
  assign slot_free = !out_valid_q || ar.out_ready;

  // Round-robin scan starting just after the previous winner.
  always_comb begin
    cand_found = 1'b0;
    cand       = '0;
    for (int k = 1; k <= INPUTS; k++) begin
      if (!cand_found && ar.in_valid[wrap_idx(int'(last_q) + k)]) begin
        cand_found = 1'b1;
        cand       = wrap_idx(int'(last_q) + k);
      end
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    grant_d = grant_q;
    ready   = '0;
    xfer    = 1'b0;
    sel     = owner_q;
    case (state_q)
      IDLE: begin
        if (cand_found && slot_free) begin
          ready[cand] = 1'b1;
          xfer        = 1'b1;
          sel         = cand;
          if (ar.in_last[cand]) begin
            last_d = cand;
          end else begin
            state_d       = LOCKED;
            owner_d       = cand;
            grant_d       = '0;
            grant_d[cand] = 1'b1;
          end
        end
      end
      LOCKED: begin
        ready[owner_q] = slot_free;
        if (ar.in_valid[owner_q] && slot_free) begin
          xfer = 1'b1;
          if (ar.in_last[owner_q]) begin
            state_d = IDLE;
            grant_d = '0;
            last_d  = owner_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= idx_t'(INPUTS - 1);
      owner_q <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
    end
  end

  // NOTE: the output flit register is a single datapath word, so it is reset along with the control flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_flit_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (xfer) begin
      out_flit_q  <= ar.in_flit[sel];
      out_last_q  <= ar.in_last[sel];
      out_valid_q <= 1'b1;
    end else if (slot_free) begin
      out_valid_q <= 1'b0;
    end
  end

  assign ar.in_ready  = ready;
  assign ar.out_flit  = out_flit_q;
  assign ar.out_last  = out_last_q;
  assign ar.out_valid = out_valid_q;
  assign grant        = grant_q;
  assign busy         = (state_q == LOCKED);

`ifdef NOC_ARB_WATCHDOG_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        stall_err_q;

  // Counts LOCKED cycles with no forward progress; any transfer or return to IDLE clears it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == IDLE || xfer) begin
      stall_cnt_d = '0;
    end else if (stall_cnt_q < 16'(STALL_LIMIT)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      stall_err_q <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      if (stall_cnt_d == 16'(STALL_LIMIT)) begin
        stall_err_q <= 1'b1;
      end
    end
  end

  assign stall_err = stall_err_q;
`endif

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Self-checking bench for noc_port_arbiter: round-robin vector table, wormhole/backpressure/reset
// sequences and a flit scoreboard; the watchdog sequence runs when NOC_ARB_WATCHDOG_EN is defined.
module tb_noc_port_arbiter;
  localparam int FW    = 32;
  localparam int N     = 5;
  localparam int LIMIT = 8;
  localparam int DEPTH = 64;

  logic         clk;
  logic         rst;
  logic [N-1:0] grant;
  logic         busy;
`ifdef NOC_ARB_WATCHDOG_EN
  logic         stall_err;
`endif

  noc_port_arbiter_if #(.FLIT_WIDTH(FW), .INPUTS(N)) ar ();

  noc_port_arbiter #(.FLIT_WIDTH(FW), .INPUTS(N), .STALL_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .ar        (ar),
    .grant     (grant),
    .busy      (busy)
`ifdef NOC_ARB_WATCHDOG_EN
    ,
    .stall_err (stall_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [FW-1:0] flit;
    logic          last;
  } sb_t;

  typedef struct {
    logic [N-1:0] mask;
    int           pkts;
    string        order;
  } rr_vec_t;

  logic [FW-1:0] src_flit [N][DEPTH];
  logic          src_last [N][DEPTH];
  int            head [N];
  int            tail [N];
  logic          hold [N];
  logic          ready_drv;

  sb_t           sb_q [$];
  int            out_src [$];
  int            out_cyc [$];
  int            cyc;
  logic          prev_stall;
  logic [FW-1:0] prev_flit;
  logic          prev_last;

  int            checks;
  int            failures;
  rr_vec_t       rr_tab [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
      hold[i] = 1'b0;
    end
    sb_q.delete();
    out_src.delete();
    out_cyc.delete();
    cyc          = 0;
    prev_stall   = 1'b0;
    prev_flit    = '0;
    prev_last    = 1'b0;
    ready_drv    = 1'b1;
    ar.in_valid  = '0;
    ar.in_last   = '0;
    ar.in_flit   = '0;
    ar.out_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Flit word = {source input, packet number, flit index}.
  task automatic add_packet(input int src, input int len, input int seq);
    for (int f = 0; f < len; f++) begin
      src_flit[src][tail[src]] = {8'(src), 8'(seq), 16'(f)};
      src_last[src][tail[src]] = (f == len - 1);
      tail[src]++;
    end
  endtask

  function automatic logic pending();
    logic any = 1'b0;
    for (int i = 0; i < N; i++) if (head[i] < tail[i]) any = 1'b1;
    return any;
  endfunction

  // One clock: drive requesters, observe handshakes at the falling edge, advance past the rising edge.
  task automatic step();
    sb_t exp_e;
    for (int i = 0; i < N; i++) begin
      if (head[i] < tail[i] && !hold[i]) begin
        ar.in_valid[i] = 1'b1;
        ar.in_flit[i]  = src_flit[i][head[i]];
        ar.in_last[i]  = src_last[i][head[i]];
      end else begin
        ar.in_valid[i] = 1'b0;
        ar.in_flit[i]  = '0;
        ar.in_last[i]  = 1'b0;
      end
    end
    ar.out_ready = ready_drv;
    @(negedge clk);
    check("ready_onehot0", 64'($onehot0(ar.in_ready)), 64'd1);
    check("grant_onehot0", 64'($onehot0(grant)), 64'd1);
    if (prev_stall) begin
      check("hold_valid", ar.out_valid, 1'b1);
      check("hold_flit", ar.out_flit, prev_flit);
      check("hold_last", ar.out_last, prev_last);
    end
    if (ar.out_valid && ar.out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_out", 64'd1, 64'd0);
      end else begin
        exp_e = sb_q.pop_front();
        check("sb_flit", {ar.out_flit, ar.out_last}, exp_e);
      end
      out_src.push_back(int'(ar.out_flit[31:24]));
      out_cyc.push_back(cyc);
    end
    for (int i = 0; i < N; i++) begin
      if (ar.in_valid[i] && ar.in_ready[i]) begin
        sb_q.push_back({ar.in_flit[i], ar.in_last[i]});
        head[i]++;
      end
    end
    prev_stall = ar.out_valid && !ar.out_ready;
    prev_flit  = ar.out_flit;
    prev_last  = ar.out_last;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input string name, input int max_cyc);
    int n = 0;
    while ((pending() || sb_q.size() != 0 || ar.out_valid) && n < max_cyc) begin
      step();
      n++;
    end
    check({name, "_drained"}, 64'(pending() || sb_q.size() != 0), 64'd0);
  endtask

  task automatic check_order(input string name, input string order);
    check({name, "_count"}, out_src.size(), order.len());
    for (int k = 0; k < order.len() && k < out_src.size(); k++)
      check($sformatf("%s_src%0d", name, k), out_src[k], int'(order[k]) - 48);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    failures = 0;

    rr_tab[0] = '{mask: 5'b01011, pkts: 2, order: "013013"};
    rr_tab[1] = '{mask: 5'b10100, pkts: 2, order: "2424"};
    rr_tab[2] = '{mask: 5'b11111, pkts: 1, order: "01234"};
    rr_tab[3] = '{mask: 5'b10000, pkts: 3, order: "444"};
    rr_tab[4] = '{mask: 5'b11001, pkts: 2, order: "034034"};

    // Reset state.
    do_reset();
    check("rst_out_valid", ar.out_valid, 1'b0);
    check("rst_out_last", ar.out_last, 1'b0);
    check("rst_out_flit", ar.out_flit, 32'h0);
    check("rst_grant", grant, 5'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", ar.in_ready, 5'b0);

    // Single 3-flit packet on input 2.
    add_packet(2, 3, 0);
    step();
    check("single_c1_valid", ar.out_valid, 1'b1);
    check("single_c1_last", ar.out_last, 1'b0);
    check("single_c1_flit", ar.out_flit, 32'h0200_0000);
    check("single_c1_grant", grant, 5'b00100);
    check("single_c1_busy", busy, 1'b1);
    step();
    check("single_c2_valid", ar.out_valid, 1'b1);
    check("single_c2_last", ar.out_last, 1'b0);
    check("single_c2_grant", grant, 5'b00100);
    step();
    check("single_c3_valid", ar.out_valid, 1'b1);
    check("single_c3_last", ar.out_last, 1'b1);
    check("single_c3_grant", grant, 5'b00000);
    check("single_c3_busy", busy, 1'b0);
    step();
    check("single_c4_valid", ar.out_valid, 1'b0);

    // Round-robin vectors, each from reset, back-to-back single-flit packets.
    for (int t = 0; t < 5; t++) begin
      do_reset();
      for (int p = 0; p < rr_tab[t].pkts; p++)
        for (int i = 0; i < N; i++)
          if (rr_tab[t].mask[i]) add_packet(i, 1, p);
      drain($sformatf("rr%0d", t), 40);
      check_order($sformatf("rr%0d", t), rr_tab[t].order);
      for (int k = 1; k < out_cyc.size(); k++)
        check($sformatf("rr%0d_nobubble%0d", t, k), out_cyc[k] - out_cyc[k-1], 1);
    end

    // Wormhole lock: input 1 pauses mid-packet while input 0 keeps requesting.
    do_reset();
    add_packet(1, 4, 0);
    step();
    add_packet(0, 1, 0);
    add_packet(0, 1, 1);
    step();
    hold[1] = 1'b1;
    repeat (2) begin
      step();
      check("worm_gap_ready0", ar.in_ready[0], 1'b0);
      check("worm_gap_grant", grant, 5'b00010);
    end
    hold[1] = 1'b0;
    drain("worm", 40);
    check_order("worm", "111100");

    // Backpressure mid-packet, then a second packet queued behind it.
    do_reset();
    add_packet(3, 4, 0);
    step();
    add_packet(0, 2, 1);
    step();
    ready_drv = 1'b0;
    repeat (5) begin
      step();
      check("bp_in_ready", ar.in_ready, 5'b0);
      check("bp_valid", ar.out_valid, 1'b1);
    end
    ready_drv = 1'b1;
    drain("bp", 40);
    check_order("bp", "333300");

    // Asynchronous reset while locked on input 4.
    do_reset();
    add_packet(4, 4, 0);
    step();
    step();
    check("rstmid_grant_before", grant, 5'b10000);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_out_valid", ar.out_valid, 1'b0);
    check("rstmid_out_flit", ar.out_flit, 32'h0);
    check("rstmid_grant", grant, 5'b0);
    check("rstmid_busy", busy, 1'b0);
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    add_packet(4, 1, 1);
    add_packet(0, 1, 1);
    drain("rstmid", 20);
    check_order("rstmid", "04");

`ifdef NOC_ARB_WATCHDOG_EN
    // Watchdog: 7 stalled cycles stay quiet, 8 trip the sticky error.
    do_reset();
    add_packet(2, 3, 0);
    step();
    hold[2] = 1'b1;
    repeat (7) step();
    check("wd_7_cycles", stall_err, 1'b0);
    hold[2] = 1'b0;
    step();
    hold[2] = 1'b1;
    repeat (7) step();
    check("wd_before_limit", stall_err, 1'b0);
    step();
    check("wd_at_limit", stall_err, 1'b1);
    hold[2] = 1'b0;
    drain("wd", 20);
    check("wd_sticky", stall_err, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
